nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs WIDTH = 4*NIBBLES bit two's-complement addition on one shared 4-bit ripple-adder slice.
- Works one nibble per cycle, LSB nibble first, chaining the carry through a register.
- Valid/ready handshake on input and output.
- Produces the full-width Sum, final unsigned Carry and signed Overflow. Overflow uses the same c3 XOR c4 rule as the 4-bit adder, applied to the top nibble.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand (>= 1). Operand width W = 4*NIBBLES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands A, B presented
- in_ready  output  1  block idle and accepting
- A  input  W  operand A
- B  input  W  operand B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- Sum  output  W  result, meaningful only while out_valid=1
- Carry  output  1  carry out of the MSB nibble
- Overflow  output  1  signed overflow of the W-bit add

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - While rst=1: state=IDLE; Sum=0, Carry=0, Overflow=0, out_valid=0; nibble index=0; carry reg=0.
  - in_ready = (state==IDLE) & ~rst.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture A and B into operand shift registers; carry reg=0, idx=0, Carry=0, Overflow=0; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the slice adds A_sh[3:0] + B_sh[3:0] + carry reg.
  - Result nibble shifts into Sum from the top, so after NIBBLES shifts nibble 0 sits at Sum[3:0].
  - carry reg <= c4. Operand registers shift right by 4. idx++.
  - When idx==NIBBLES-1: Carry <= c4, Overflow <= c3^c4 of that nibble, go to DONE.
  - Intermediate Sum contents are don't-care for the consumer.
- DONE:
  - out_valid=1. Sum, Carry and Overflow are held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready=1: go to IDLE at the next edge; out_valid drops.
- Latency and throughput:
  - out_valid rises exactly NIBBLES cycles after the accepting edge.
  - If out_ready is already 1, the output handshake completes in the first DONE cycle.
  - Minimum initiation interval is NIBBLES+2 cycles. There is no overlap of operations.
- Outputs after DONE:
  - Sum, Carry and Overflow keep their values in IDLE until the next capture.
  - Carry and Overflow clear at capture.
- Boundary conditions:
  - NIBBLES=1: one RUN cycle. idx counter width is max(1, clog2(NIBBLES)).
  - Carry ripples fully across nibbles, e.g. FFFF+0001 → 0000 with Carry=1.
- Reset mid-operation (RUN or DONE): abort immediately, no out_valid pulse; next cycle is IDLE with the reset values.
- Simultaneous events: in_valid held high during DONE with out_ready=1 is not accepted in that cycle. It is accepted in the following IDLE cycle.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled only at capture.
  - sub=1: B is inverted at capture and the initial carry reg = 1, giving A-B.
  - Carry = NOT borrow.
  - Overflow = signed subtraction overflow (same c3^c4 rule).
- Undefined: port sub is absent; add-only; initial carry is always 0.

Decomposition:
- Package nibble_adder_pkg:
  - NIBBLE_W=4.
  - State enum {IDLE, RUN, DONE}.
- One sub-module, nibble_add_slice: 4-bit ripple slice with inputs a, b, cin and outputs s[3:0], c3 (carry into bit 3) and c4 (carry out).
- The controller instantiates exactly one slice.

Test Plan:
1. NIBBLES=4, A=7FFF, B=0001 → Sum=8000, Carry=0, Overflow=1; out_valid exactly 4 cycles after the accept edge.
2. A=FFFF, B=0001 → Sum=0000, Carry=1, Overflow=0 (full carry ripple); A=1234, B=4321 → Sum=5555, Carry=0, Overflow=0.
3. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 → Sum/Carry/Overflow stable, in_ready=0, no capture; out_ready=1 → IDLE, next op accepted one cycle later.
4. rst=1 in the second RUN cycle → next cycle IDLE, out_valid=0, Sum=0, in_ready=1; a subsequent A=0F0F, B=00F1 → Sum=1000.
5. NIBBLE_SERIAL_SUB_EN, sub=1, A=8000, B=0001 → Sum=7FFF, Carry=1, Overflow=1; sub=1, A=0000, B=0001 → Sum=FFFF, Carry=0, Overflow=0.
6. NIBBLES=1 build: A=7, B=1 → Sum=8, Overflow=1, Carry=0, latency 1 cycle; back-to-back ops with out_ready tied high → initiation interval 3 cycles.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared constants for the nibble-serial adder: slice width and controller state encodings.
package nibble_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    // Controller states, kept as plain 2-bit constants for legacy tool compatibility.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/nibble_add_slice.sv
// 4-bit adder slice: sum nibble, carry into bit 3 (c3) and carry out (c4).
module nibble_add_slice
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c3,
    output logic                c4
);

    logic [NIBBLE_W-1:0] low_sum;
    logic [NIBBLE_W:0]   full_sum;

    // c3 is the carry out of the low three bits; c4 is the carry out of the whole nibble.
    always_comb begin
        low_sum  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]} + {{(NIBBLE_W-1){1'b0}}, cin};
        full_sum = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
        s        = full_sum[NIBBLE_W-1:0];
        c3       = low_sum[NIBBLE_W-1];
        c4       = full_sum[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial W-bit adder: one shared 4-bit slice, LSB nibble first, carry chained in a register.
// Optional subtract support is enabled by defining NIBBLE_SERIAL_SUB_EN (adds input port sub).
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic                          sub,
`endif
    input  logic [NIBBLE_W*NIBBLES-1:0]   A,
    input  logic [NIBBLE_W*NIBBLES-1:0]   B,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   Sum,
    output logic                          Carry,
    output logic                          Overflow
);

    localparam int unsigned W    = NIBBLE_W * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cy_q, cy_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;

    logic [NIBBLE_W-1:0]   slice_s;
    logic                  slice_c3;
    logic                  slice_c4;
    logic [W+NIBBLE_W-1:0] sum_ext;
    logic                  sub_eff;

`ifdef NIBBLE_SERIAL_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    nibble_add_slice u_slice (
        .a   (a_q[NIBBLE_W-1:0]),
        .b   (b_q[NIBBLE_W-1:0]),
        .cin (cy_q),
        .s   (slice_s),
        .c3  (slice_c3),
        .c4  (slice_c4)
    );

    // New nibble enters at the top; after NIBBLES shifts nibble 0 lands in Sum[3:0].
    assign sum_ext = {slice_s, sum_q};

    // Handshake outputs; gated by rst so an aborted operation never shows out_valid.
    always_comb begin
        in_ready  = (state_q == IDLE) & ~rst;
        out_valid = (state_q == DONE) & ~rst;
        Sum       = sum_q;
        Carry     = carry_q;
        Overflow  = ovf_q;
    end

    // Next-state logic: capture in IDLE, one nibble per cycle in RUN, hold until accepted in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    // Subtraction is A + ~B + 1: invert B once here and seed the carry.
                    b_d     = sub_eff ? ~B : B;
                    cy_d    = sub_eff;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d = sum_ext[W+NIBBLE_W-1:NIBBLE_W];
                a_d   = a_q >> NIBBLE_W;
                b_d   = b_q >> NIBBLE_W;
                cy_d  = slice_c4;
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxLast) begin
                    carry_d = slice_c4;
                    ovf_d   = slice_c3 ^ slice_c4;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: a NIBBLES=4 instance and a NIBBLES=1 instance.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [3:0]  sum1;
    logic        carry1;
    logic        ovf1;

`ifdef NIBBLE_SERIAL_SUB_EN
    logic        sub  = 1'b0;
    logic        sub1 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (sum),
        .Carry     (carry),
        .Overflow  (ovf)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub       (sub1),
`endif
        .A         (a1),
        .B         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .Sum       (sum1),
        .Carry     (carry1),
        .Overflow  (ovf1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operation on the 4-nibble instance and wait (bounded) for out_valid.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input string tag);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 32'd4);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // 7FFF + 0001: signed overflow
        run_op(16'h7FFF, 16'h0001, "t1");
        chk("t1_sum", 32'(sum), 32'h8000);
        chk("t1_carry", 32'(carry), 32'd0);
        chk("t1_ovf", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_out_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_sum_held_idle", 32'(sum), 32'h8000);
        chk("t1_in_ready_idle", 32'(in_ready), 32'd1);

        // FFFF + 0001: carry ripples through all nibbles
        run_op(16'hFFFF, 16'h0001, "t2a");
        chk("t2a_sum", 32'(sum), 32'h0000);
        chk("t2a_carry", 32'(carry), 32'd1);
        chk("t2a_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        run_op(16'h1234, 16'h4321, "t2b");
        chk("t2b_sum", 32'(sum), 32'h5555);
        chk("t2b_carry", 32'(carry), 32'd0);
        chk("t2b_ovf", 32'(ovf), 32'd0);

        // Backpressure in DONE with in_valid high
        a        = 16'h1111;
        b        = 16'h1111;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_bp_out_valid", 32'(out_valid), 32'd1);
            chk("t3_bp_in_ready", 32'(in_ready), 32'd0);
            chk("t3_bp_sum", 32'(sum), 32'h5555);
            chk("t3_bp_carry", 32'(carry), 32'd0);
            chk("t3_bp_ovf", 32'(ovf), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_release_out_valid", 32'(out_valid), 32'd0);
        chk("t3_release_in_ready", 32'(in_ready), 32'd1);
        chk("t3_release_sum", 32'(sum), 32'h5555);
        step();
        in_valid = 1'b0;
        chk("t3_accept_in_ready", 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        chk("t3_latency", cnt, 32'd4);
        chk("t3_sum", 32'(sum), 32'h2222);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset during the second RUN cycle
        a        = 16'h5555;
        b        = 16'h5555;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t4_rst_out_valid", 32'(out_valid), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t4_after_in_ready", 32'(in_ready), 32'd1);
        chk("t4_after_out_valid", 32'(out_valid), 32'd0);
        chk("t4_after_sum", 32'(sum), 32'h0);
        step();
        chk("t4_still_idle", 32'(out_valid), 32'd0);
        run_op(16'h0F0F, 16'h00F1, "t4");
        chk("t4_sum", 32'(sum), 32'h1000);
        chk("t4_carry", 32'(carry), 32'd0);
        chk("t4_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

`ifdef NIBBLE_SERIAL_SUB_EN
        // Subtraction
        sub = 1'b1;
        run_op(16'h8000, 16'h0001, "t5a");
        sub = 1'b0;
        chk("t5a_sum", 32'(sum), 32'h7FFF);
        chk("t5a_carry", 32'(carry), 32'd1);
        chk("t5a_ovf", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        sub = 1'b1;
        run_op(16'h0000, 16'h0001, "t5b");
        sub = 1'b0;
        chk("t5b_sum", 32'(sum), 32'hFFFF);
        chk("t5b_carry", 32'(carry), 32'd0);
        chk("t5b_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif

        // NIBBLES=1 instance, out_ready tied high, in_valid held: II of 3 cycles
        chk("t6_idle_in_ready", 32'(in_ready1), 32'd1);
        a1        = 4'h7;
        b1        = 4'h1;
        in_valid1 = 1'b1;
        step();
        chk("t6_accept_in_ready", 32'(in_ready1), 32'd0);
        chk("t6_run_out_valid", 32'(out_valid1), 32'd0);
        step();
        chk("t6_done_out_valid", 32'(out_valid1), 32'd1);
        chk("t6_sum", 32'(sum1), 32'h8);
        chk("t6_ovf", 32'(ovf1), 32'd1);
        chk("t6_carry", 32'(carry1), 32'd0);
        a1 = 4'h3;
        b1 = 4'h4;
        step();
        chk("t6_idle_out_valid", 32'(out_valid1), 32'd0);
        chk("t6_idle_in_ready2", 32'(in_ready1), 32'd1);
        step();
        in_valid1 = 1'b0;
        chk("t6_accept2_in_ready", 32'(in_ready1), 32'd0);
        step();
        chk("t6_done2_out_valid", 32'(out_valid1), 32'd1);
        chk("t6_sum2", 32'(sum1), 32'h7);
        chk("t6_ovf2", 32'(ovf1), 32'd0);
        chk("t6_carry2", 32'(carry1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
